// File: rtl/rc5_encrypt_if.sv
// Request/result bundle of the RC5 encryptor: block handshake, S-table read port and ciphertext.
interface rc5_encrypt_if #(
    parameter int W = 32,
    parameter int R = 12
);
    localparam int T        = 2 * (R + 1);
    localparam int T_LENGTH = $clog2(T);

    logic                iStart;
    logic [W-1:0]        iA;
    logic [W-1:0]        iB;
    logic [W-1:0]        iS_sub_i;
    logic [T_LENGTH-1:0] oS_address;
    logic [W-1:0]        oA;
    logic [W-1:0]        oB;
    logic                oBusy;
    logic                oDone;

    modport slave (
        input  iStart, iA, iB, iS_sub_i,
        output oS_address, oA, oB, oBusy, oDone
    );

    modport master (
        output iStart, iA, iB, iS_sub_i,
        input  oS_address, oA, oB, oBusy, oDone
    );
endinterface

// File: rtl/rc5_encrypt.sv
// Iterative RC5 encryptor: one S-table word per three cycles (address, memory read, round step).
module rc5_encrypt #(
    parameter int W = 32,
    parameter int R = 12
) (
    input  logic         clk,
    input  logic         rst,
    rc5_encrypt_if.slave bus
);
    localparam int T        = 2 * (R + 1);
    localparam int T_LENGTH = $clog2(T);
    localparam int SH       = $clog2(W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        READ    = 3'd2,
        OPERATE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d;
    logic [W-1:0]        oa_q, oa_d, ob_q, ob_d;
    logic [T_LENGTH-1:0] cnt_q, cnt_d, addr_q, addr_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [W-1:0]        a_op, b_op;
    logic                last_step;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [SH-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    // Odd steps read a_q, which already holds the A produced by the preceding even step.
    always_comb begin
        a_op = a_q;
        b_op = b_q;
        if (!cnt_q[0]) begin
            if (cnt_q[T_LENGTH-1:1] == '0) a_op = a_q + bus.iS_sub_i;
            else                           a_op = rotl(a_q ^ b_q, b_q[SH-1:0]) + bus.iS_sub_i;
        end else begin
            if (cnt_q[T_LENGTH-1:1] == '0) b_op = b_q + bus.iS_sub_i;
            else                           b_op = rotl(b_q ^ a_q, a_q[SH-1:0]) + bus.iS_sub_i;
        end
    end

    assign last_step = (cnt_q == T_LENGTH'(T - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        oa_d    = oa_q;
        ob_d    = ob_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    a_d     = bus.iA;
                    b_d     = bus.iB;
                    cnt_d   = '0;
                    addr_d  = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                busy_d  = 1'b1;
                state_d = READ;
            end
            READ:    state_d = OPERATE;
            OPERATE: begin
                a_d = a_op;
                b_d = b_op;
                if (last_step) begin
                    oa_d    = a_op;
                    ob_d    = b_op;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    addr_d  = cnt_q + 1'b1;
                    state_d = ADDR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            oa_q    <= '0;
            ob_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            oa_q    <= oa_d;
            ob_q    <= ob_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.oS_address = addr_q;
    assign bus.oA         = oa_q;
    assign bus.oB         = ob_q;
    assign bus.oBusy      = busy_q;
    assign bus.oDone      = done_q;
endmodule

// File: tb/tb_rc5_encrypt.sv
// Directed bench for rc5_encrypt: RC5-32/12 with the zero-key S table, plus a reduced R=1 instance.
module tb_rc5_encrypt;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    rc5_encrypt_if #(.W(32), .R(12)) b0 ();
    rc5_encrypt_if #(.W(32), .R(1))  b1 ();

    rc5_encrypt #(.W(32), .R(12)) dut0 (.clk(clk), .rst(rst_n), .bus(b0));
    rc5_encrypt #(.W(32), .R(1))  dut1 (.clk(clk), .rst(rst_n), .bus(b1));

    logic [31:0] s0_mem [0:25];
    logic [31:0] s1_mem [0:3];

    // Synchronous S-table memories: data one cycle after the address.
    always @(posedge clk) b0.iS_sub_i <= s0_mem[b0.oS_address];
    always @(posedge clk) b1.iS_sub_i <= s1_mem[b1.oS_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        int m;
        m = n & 31;
        return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
    endfunction

    // Standard RC5-32 key expansion for a 16-byte all-zero key.
    task automatic build_zero_key();
        logic [31:0] l [0:3];
        logic [31:0] a, b;
        int i, j;
        s0_mem[0] = 32'hB7E15163;
        for (int k = 1; k < 26; k++) s0_mem[k] = s0_mem[k-1] + 32'h9E3779B9;
        for (int k = 0; k < 4; k++) l[k] = '0;
        a = '0; b = '0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            s0_mem[i] = rotl32(s0_mem[i] + a + b, 3);
            a = s0_mem[i];
            l[j] = rotl32(l[j] + a + b, int'(a + b));
            b = l[j];
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    task automatic model_enc(input logic [31:0] pa, pb, output logic [31:0] ca, cb);
        ca = pa + s0_mem[0];
        cb = pb + s0_mem[1];
        for (int i = 1; i <= 12; i++) begin
            ca = rotl32(ca ^ cb, int'(cb)) + s0_mem[2*i];
            cb = rotl32(cb ^ ca, int'(ca)) + s0_mem[2*i+1];
        end
    endtask

    // Runs one block on dut0; returns in the DONE cycle (or after the bound).
    task automatic run0(input logic [31:0] a, b, input bit noise, output int lat, output int busy_n);
        @(negedge clk);
        b0.iStart = 1'b1; b0.iA = a; b0.iB = b;
        @(negedge clk);
        b0.iStart = 1'b0;
        lat = -1; busy_n = 0;
        for (int n = 0; n < 120; n++) begin
            if (b0.oDone) begin
                lat = n;
                break;
            end
            if (b0.oBusy) busy_n++;
            chk("addr_seq", b0.oS_address, n / 3);
            if (noise && (n % 7 == 1)) begin
                b0.iStart = 1'b1; b0.iA = $urandom; b0.iB = $urandom;
            end else begin
                b0.iStart = 1'b0;
            end
            @(negedge clk);
        end
        b0.iStart = 1'b0;
    endtask

    int          lat, bsy, ndone, nbusy, d1, d2;
    logic [31:0] ea, eb;

    initial begin
        rst_n = 1'b1;
        b0.iStart = 1'b0; b0.iA = '0; b0.iB = '0;
        b1.iStart = 1'b0; b1.iA = '0; b1.iB = '0;
        s1_mem[0] = 32'd5; s1_mem[1] = 32'd7; s1_mem[2] = '0; s1_mem[3] = '0;
        build_zero_key();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_oA", b0.oA, 0);
        chk("rst_oB", b0.oB, 0);
        chk("rst_oBusy", b0.oBusy, 0);
        chk("rst_oDone", b0.oDone, 0);
        chk("rst_addr", b0.oS_address, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero key, zero plaintext: published RC5-32/12/16 vector.
        run0(32'h0, 32'h0, 1'b0, lat, bsy);
        chk("zk_latency", lat, 78);
        chk("zk_busy_cycles", bsy, 77);
        chk("zk_oA", b0.oA, 32'hEEDBA521);
        chk("zk_oB", b0.oB, 32'h6D8F4B15);
        chk("zk_done_addr", b0.oS_address, 25);
        chk("zk_done_busy", b0.oBusy, 0);
        // iStart during DONE must not start a block.
        b0.iStart = 1'b1; b0.iA = 32'h1; b0.iB = 32'h2;
        @(negedge clk);
        b0.iStart = 1'b0;
        chk("done_pulse_width", b0.oDone, 0);
        chk("done_start_ignored_addr", b0.oS_address, 25);
        repeat (5) @(negedge clk);
        chk("done_start_ignored_busy", b0.oBusy, 0);
        chk("hold_oA", b0.oA, 32'hEEDBA521);
        chk("hold_oB", b0.oB, 32'h6D8F4B15);

        // Nonzero plaintext with iStart/iA/iB disturbances inside the block.
        model_enc(32'h01234567, 32'h89ABCDEF, ea, eb);
        run0(32'h01234567, 32'h89ABCDEF, 1'b1, lat, bsy);
        chk("noise_latency", lat, 78);
        chk("noise_oA", b0.oA, ea);
        chk("noise_oB", b0.oB, eb);
        repeat (3) @(negedge clk);

        // iStart held for 200 cycles: blocks end at 78 and 158; a third starts at 160.
        b0.iA = '0; b0.iB = '0;
        b0.iStart = 1'b1;
        @(negedge clk);
        ndone = 0; d1 = -1; d2 = -1;
        for (int c = 0; c < 200; c++) begin
            if (b0.oDone) begin
                ndone++;
                if (ndone == 1) d1 = c;
                if (ndone == 2) d2 = c;
            end
            @(negedge clk);
        end
        b0.iStart = 1'b0;
        chk("held_done_count", ndone, 2);
        chk("held_done1_cycle", d1, 78);
        chk("held_done2_cycle", d2, 158);
        chk("held_oA", b0.oA, 32'hEEDBA521);
        chk("held_oB", b0.oB, 32'h6D8F4B15);

        // Now at cycle 40 of the third block: asynchronous reset mid-block.
        chk("mid_busy_before_rst", b0.oBusy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_oA", b0.oA, 0);
        chk("midrst_oB", b0.oB, 0);
        chk("midrst_oBusy", b0.oBusy, 0);
        chk("midrst_oDone", b0.oDone, 0);
        chk("midrst_addr", b0.oS_address, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0; nbusy = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (b0.oDone) ndone++;
            if (b0.oBusy) nbusy++;
        end
        chk("aborted_no_done", ndone, 0);
        chk("aborted_no_busy", nbusy, 0);
        run0(32'h0, 32'h0, 1'b0, lat, bsy);
        chk("after_rst_latency", lat, 78);
        chk("after_rst_oA", b0.oA, 32'hEEDBA521);
        chk("after_rst_oB", b0.oB, 32'h6D8F4B15);
        repeat (2) @(negedge clk);

        // All-zero S table with zero plaintext stays zero.
        for (int k = 0; k < 26; k++) s0_mem[k] = '0;
        run0(32'h0, 32'h0, 1'b0, lat, bsy);
        chk("s0_latency", lat, 78);
        chk("s0_busy_cycles", bsy, 77);
        chk("s0_oA", b0.oA, 0);
        chk("s0_oB", b0.oB, 0);

        // R=1 instance: steps give A=6, B=9, A=0x1E00, B=0x1E09.
        @(negedge clk);
        b1.iStart = 1'b1; b1.iA = 32'd1; b1.iB = 32'd2;
        @(negedge clk);
        b1.iStart = 1'b0; b1.iA = 32'hDEAD; b1.iB = 32'hBEEF;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (b1.oDone) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        chk("r1_latency", lat, 12);
        chk("r1_oA", b1.oA, 32'h1E00);
        chk("r1_oB", b1.oB, 32'h1E09);
        chk("r1_done_addr", b1.oS_address, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rc5_encrypt.md
RC5_ENCRYPT -- requirements
Module: rc5_encrypt

Interface
REQ-001 SHALL have parameter W, default 32, meaning data word width in bits (power of two).
REQ-002 SHALL have parameter R, default 12, meaning number of RC5 rounds.
REQ-003 SHALL derive the local parameter T = 2*(R+1), the S-table word count, and the local parameter T_LENGTH = $clog2(T).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port iStart  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port iA  input  W  plaintext word A, captured with iStart.
REQ-008 SHALL have port iB  input  W  plaintext word B, captured with iStart.
REQ-009 SHALL have port iS_sub_i  input  W  S-table read data; synchronous memory, valid one cycle after oS_address is presented.
REQ-010 SHALL have port oS_address  output  T_LENGTH  S-table read address, registered.
REQ-011 SHALL have port oA  output  W  ciphertext word A, registered.
REQ-012 SHALL have port oB  output  W  ciphertext word B, registered.
REQ-013 SHALL have port oBusy  output  1  high from the cycle after iStart is accepted until DONE is reached.
REQ-014 SHALL have port oDone  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement the FSM states IDLE, ADDR, READ, OPERATE and DONE, with registered state.
REQ-016 IDLE: if iStart=1, SHALL load rA<=iA, rB<=iB, rCount<=0 and oS_address<=0, then go to ADDR; otherwise SHALL stay in IDLE.
REQ-017 ADDR SHALL go to READ, and READ SHALL go to OPERATE, with oS_address held in both states.
REQ-018 OPERATE, with k=rCount and S=iS_sub_i, SHALL apply: k=0: rA<=rA+S; k=1: rB<=rB+S; k even >=2: rA<=((rA^rB)<<<rB[log2(W)-1:0])+S; k odd >=3: rB<=((rB^rA)<<<rA[log2(W)-1:0])+S.
REQ-019 The odd-k update in OPERATE SHALL use the rA value already updated by the preceding even k.
REQ-020 All additions SHALL be modulo 2^W, and rotate-left SHALL be by the low log2(W) bits only (a rotate amount of 0 leaves the value unchanged).
REQ-021 OPERATE SHALL set rCount<=k+1 and oS_address<=k+1, then go to ADDR if k<T-1.
REQ-022 OPERATE with k=T-1 SHALL instead load oA and oB with the final rA and rB, then go to DONE.
REQ-023 DONE SHALL hold oDone=1 and oBusy=0 for exactly one cycle, then go to IDLE.
REQ-024 Latency SHALL be 3*T cycles from the rising edge that samples iStart to the cycle in which oDone=1 (78 cycles for R=12).
REQ-025 Addresses SHALL be issued in the order 0,1,...,T-1, each exactly once per block, and oS_address SHALL never exceed T-1.
REQ-026 iStart SHALL be ignored outside IDLE, and iA/iB SHALL be ignored after capture.
REQ-027 iStart=1 in the cycle that DONE is active SHALL be ignored; a new block SHALL be accepted only in IDLE.
REQ-028 oA and oB SHALL hold their values until the next completion.
REQ-029 An unused state encoding SHALL go to IDLE on the next clock edge.

Reset
REQ-030 rst=0 SHALL, asynchronously and at any time including mid-block, force state=IDLE.
REQ-031 rst=0 SHALL clear rA, rB, rCount, oS_address, oA, oB, oBusy and oDone to 0.
REQ-032 After rst deasserts, the block SHALL do nothing until iStart is sampled in IDLE, and SHALL produce no oDone for any aborted block.

Verification
REQ-033 With W=32, R=12, the S table from the all-zero 16-byte key and iA=iB=0 -> oA=32'hEEDBA521, oB=32'h6D8F4B15, with oDone at cycle 78.
REQ-034 With R=1, S={5,7,0,0}, iA=1, iB=2 -> rA/rB after k=0..3 equal 6, 9, 32'h1E00, 32'h1E09, and oA=32'h1E00, oB=32'h1E09.
REQ-035 With iStart held high for 200 cycles -> exactly two blocks complete; oDone pulses at cycles 78 and 158, and oS_address sequences 0..25 twice.
REQ-036 With rst=0 asserted at cycle 40 of a block -> all outputs are 0 immediately, there is no oDone, and a following iStart gives the correct result at cycle 78 after it.
REQ-037 With iStart pulsed during ADDR, READ or OPERATE -> no effect: iA/iB are not recaptured and the address order is unchanged.
REQ-038 With all S=0 and iA=iB=0 -> oA=oB=0, and oBusy is high for exactly 77 cycles.
